// File: rtl/elvm_pkg.sv
// elvm_pkg: shared opcodes, FSM states, register indices and instruction field offsets for the ELVM core
package elvm_pkg;
  localparam logic [4:0] OP_MOV   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_LOAD  = 5'd3;
  localparam logic [4:0] OP_STORE = 5'd4;
  localparam logic [4:0] OP_PUTC  = 5'd5;
  localparam logic [4:0] OP_EXIT  = 5'd6;
  localparam logic [4:0] OP_GETC  = 5'd7;
  localparam logic [4:0] OP_EQ    = 5'd8;
  localparam logic [4:0] OP_NE    = 5'd9;
  localparam logic [4:0] OP_LT    = 5'd10;
  localparam logic [4:0] OP_GT    = 5'd11;
  localparam logic [4:0] OP_LE    = 5'd12;
  localparam logic [4:0] OP_GE    = 5'd13;
  localparam logic [4:0] OP_JEQ   = 5'd14;
  localparam logic [4:0] OP_JNE   = 5'd15;
  localparam logic [4:0] OP_JLT   = 5'd16;
  localparam logic [4:0] OP_JGT   = 5'd17;
  localparam logic [4:0] OP_JLE   = 5'd18;
  localparam logic [4:0] OP_JGE   = 5'd19;
  localparam logic [4:0] OP_JMP   = 5'd20;
  typedef enum logic [2:0] {ST_FETCH, ST_EXEC, ST_MEM, ST_OUT, ST_IN, ST_HALT} state_t;
  localparam logic [2:0] REG_A  = 3'd0;
  localparam logic [2:0] REG_B  = 3'd1;
  localparam logic [2:0] REG_C  = 3'd2;
  localparam logic [2:0] REG_D  = 3'd3;
  localparam logic [2:0] REG_SP = 3'd4;
  localparam logic [2:0] REG_BP = 3'd5;
  function automatic int f_op_msb(input int instr_w);
    return instr_w - 1;
  endfunction
  function automatic int f_imm_bit(input int instr_w);
    return instr_w - 6;
  endfunction
  function automatic int f_rd_msb(input int instr_w);
    return instr_w - 7;
  endfunction
  function automatic int f_rs_msb(input int instr_w);
    return instr_w - 10;
  endfunction
endpackage

// File: rtl/elvm_core_mc_if.sv
// elvm_core_mc_if: core bus bundle (ROM fetch, data-RAM req/ack, putc/getc streams, halted); master = core, slave = environment
interface elvm_core_mc_if #(
  parameter int WORD_W  = 24,
  parameter int PC_W    = 8,
  parameter int DADDR_W = 12,
  parameter int INSTR_W = 24
);
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               dmem_req;
  logic               dmem_we;
  logic [DADDR_W-1:0] dmem_addr;
  logic [WORD_W-1:0]  dmem_wdata;
  logic [WORD_W-1:0]  dmem_rdata;
  logic               dmem_ack;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_data;
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_data;
  logic               in_eof;
  logic               halted;
  modport master (
    output imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, out_valid, out_data, in_ready, halted,
    input  imem_data, dmem_rdata, dmem_ack, out_ready, in_valid, in_data, in_eof
  );
  modport slave (
    input  imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, out_valid, out_data, in_ready, halted,
    output imem_data, dmem_rdata, dmem_ack, out_ready, in_valid, in_data, in_eof
  );
endinterface

// File: rtl/elvm_alu.sv
// elvm_alu: combinational mov/add/sub result and unsigned compare/branch condition; i_op, i_a (rd), i_b (operand) -> o_res, o_cond
module elvm_alu
  import elvm_pkg::*;
#(
  parameter int WORD_W = 24
) (
  input  logic [4:0]        i_op,
  input  logic [WORD_W-1:0] i_a,
  input  logic [WORD_W-1:0] i_b,
  output logic [WORD_W-1:0] o_res,
  output logic              o_cond
);
  logic [4:0] w_sel;
  always_comb begin
    w_sel  = (i_op >= OP_JEQ) ? i_op - OP_JEQ : i_op - OP_EQ;
    o_cond = (w_sel == 5'd0) ? (i_a == i_b) :
             (w_sel == 5'd1) ? (i_a != i_b) :
             (w_sel == 5'd2) ? (i_a <  i_b) :
             (w_sel == 5'd3) ? (i_a >  i_b) :
             (w_sel == 5'd4) ? (i_a <= i_b) : (i_a >= i_b);
    o_res  = (i_op == OP_MOV) ? i_b :
             (i_op == OP_ADD) ? i_a + i_b :
             (i_op == OP_SUB) ? i_a - i_b : WORD_W'(o_cond);
  end
endmodule

// File: rtl/elvm_core_mc.sv
// elvm_core_mc: multi-cycle ELVM CPU core; clk, rst (sync active-high), bus (ROM fetch, data-RAM req/ack, putc/getc streams, halted)
module elvm_core_mc
  import elvm_pkg::*;
#(
  parameter int WORD_W  = 24,
  parameter int IMM_W   = 12,
  parameter int PC_W    = 8,
  parameter int DADDR_W = 12,
  parameter int INSTR_W = 24
) (
  input logic            clk,
  input logic            rst,
  elvm_core_mc_if.master bus
);
  localparam int OP_MSB  = f_op_msb(INSTR_W);
  localparam int IMM_BIT = f_imm_bit(INSTR_W);
  localparam int RD_MSB  = f_rd_msb(INSTR_W);
  localparam int RS_MSB  = f_rs_msb(INSTR_W);
  if (INSTR_W != 12 + IMM_W) begin : g_bad_instr_w
    $error("elvm_core_mc: INSTR_W must equal 12 + IMM_W");
  end
  state_t             r_state, w_state_nxt;
  logic [INSTR_W-1:0] r_ir;
  logic [WORD_W-1:0]  r_reg [6];
  logic [PC_W-1:0]    r_pc, w_pc_nxt, w_pc_inc;
  logic               r_dmem_req, r_dmem_we, r_out_valid, r_in_ready, r_halted;
  logic [DADDR_W-1:0] r_dmem_addr;
  logic [WORD_W-1:0]  r_dmem_wdata;
  logic [7:0]         r_out_data;
  logic [4:0]         w_op;
  logic               w_is_imm, w_is_br, w_take, w_wr_en;
  logic [2:0]         w_rd, w_rs;
  logic [IMM_W-1:0]   w_imm;
  logic [WORD_W-1:0]  w_rd_val, w_rs_val, w_src, w_alu_res, w_wr_data;
  assign w_op     = r_ir[OP_MSB -: 5];
  assign w_is_imm = r_ir[IMM_BIT];
  assign w_rd     = r_ir[RD_MSB -: 3];
  assign w_rs     = r_ir[RS_MSB -: 3];
  assign w_imm    = r_ir[IMM_W-1:0];
  assign w_rd_val = (w_rd < 3'd6) ? r_reg[w_rd] : '0;
  assign w_rs_val = (w_rs < 3'd6) ? r_reg[w_rs] : '0;
  assign w_src    = w_is_imm ? WORD_W'(w_imm) : w_rs_val;
  assign w_is_br  = (w_op >= OP_JEQ) && (w_op <= OP_JGE);
  assign w_pc_inc = r_pc + PC_W'(1);
  // conditional jumps always compare two registers, even when is_imm supplies the target
  elvm_alu #(.WORD_W(WORD_W)) u_alu (
    .i_op  (w_op),
    .i_a   (w_rd_val),
    .i_b   (w_is_br ? w_rs_val : w_src),
    .o_res (w_alu_res),
    .o_cond(w_take)
  );
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FETCH: w_state_nxt = ST_EXEC;
      ST_EXEC:  w_state_nxt = (w_op == OP_LOAD || w_op == OP_STORE) ? ST_MEM :
                              (w_op == OP_PUTC) ? ST_OUT :
                              (w_op == OP_GETC) ? ST_IN  :
                              (w_op == OP_EXIT) ? ST_HALT : ST_FETCH;
      ST_MEM:   w_state_nxt = bus.dmem_ack  ? ST_FETCH : ST_MEM;
      ST_OUT:   w_state_nxt = bus.out_ready ? ST_FETCH : ST_OUT;
      ST_IN:    w_state_nxt = bus.in_valid  ? ST_FETCH : ST_IN;
      default:  w_state_nxt = ST_HALT;
    endcase
  end
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_data = w_alu_res;
    w_pc_nxt  = r_pc;
    if (r_state == ST_EXEC) begin
      w_wr_en  = (w_op <= OP_SUB) || (w_op >= OP_EQ && w_op <= OP_GE);
      w_pc_nxt = (w_op == OP_JMP) ? (w_is_imm ? w_imm[PC_W-1:0] : w_rs_val[PC_W-1:0]) :
                 (w_is_br && w_take) ? w_imm[PC_W-1:0] :
                 (w_op >= OP_LOAD && w_op <= OP_GETC) ? r_pc : w_pc_inc;
    end else if (r_state == ST_MEM) begin
      w_wr_en   = bus.dmem_ack && !r_dmem_we;
      w_wr_data = bus.dmem_rdata;
      w_pc_nxt  = bus.dmem_ack ? w_pc_inc : r_pc;
    end else if (r_state == ST_OUT) begin
      w_pc_nxt = bus.out_ready ? w_pc_inc : r_pc;
    end else if (r_state == ST_IN) begin
      w_wr_en   = bus.in_valid;
      w_wr_data = bus.in_eof ? '0 : WORD_W'(bus.in_data);
      w_pc_nxt  = bus.in_valid ? w_pc_inc : r_pc;
    end
  end
  // handshake outputs follow the next state, so they are flops that hold steady while waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= '0;
      r_ir         <= '0;
      r_reg        <= '{default: '0};
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_in_ready   <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      if (r_state == ST_FETCH) r_ir <= bus.imem_data;
      if (w_wr_en && w_rd < 3'd6) r_reg[w_rd] <= w_wr_data;
      if (r_state == ST_EXEC && (w_op == OP_LOAD || w_op == OP_STORE)) begin
        r_dmem_we    <= w_op == OP_STORE;
        r_dmem_addr  <= w_src[DADDR_W-1:0];
        r_dmem_wdata <= w_rd_val;
      end
      if (r_state == ST_EXEC && w_op == OP_PUTC) r_out_data <= w_rd_val[7:0];
      r_dmem_req  <= w_state_nxt == ST_MEM;
      r_out_valid <= w_state_nxt == ST_OUT;
      r_in_ready  <= w_state_nxt == ST_IN;
      r_halted    <= w_state_nxt == ST_HALT;
    end
  end
  assign bus.imem_addr  = r_pc;
  assign bus.dmem_req   = r_dmem_req;
  assign bus.dmem_we    = r_dmem_we;
  assign bus.dmem_addr  = r_dmem_addr;
  assign bus.dmem_wdata = r_dmem_wdata;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.in_ready   = r_in_ready;
  assign bus.halted     = r_halted;
endmodule

// File: tb/tb_elvm_core_mc.sv
// tb_elvm_core_mc: scoreboard bench for elvm_core_mc driving ROM, data RAM and putc/getc streams
module tb_elvm_core_mc;
  import elvm_pkg::*;
  typedef struct {logic [11:0] a; logic [23:0] d;} st_t;
  typedef struct {logic [7:0] c; logic eof; int w;} in_t;
  logic        clk, rst;
  logic [23:0] rom [256];
  logic [23:0] mem [4096];
  st_t         st_q[$];
  logic [7:0]  out_q[$];
  in_t         in_q[$];
  int n_tests = 0, n_fail = 0, mem_dly = 1, cur_wait = 0, beats = 0, req_cyc = 0, rdy_cyc = 0, cyc = 0;
  elvm_core_mc_if #(.WORD_W(24), .PC_W(8), .DADDR_W(12), .INSTR_W(24)) bus ();
  elvm_core_mc #(.WORD_W(24), .IMM_W(12), .PC_W(8), .DADDR_W(12), .INSTR_W(24)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  assign bus.imem_data = rom[bus.imem_addr];
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [23:0] ins(input logic [4:0] op, input logic im, input logic [2:0] rd, input logic [2:0] rs, input logic [11:0] imm);
    return {op, im, rd, rs, imm};
  endfunction
  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = ins(OP_EXIT, 1'b0, 3'd0, 3'd0, 12'd0);
  endtask
  task automatic exp_st(input logic [11:0] a, input logic [23:0] d);
    st_t e;
    e.a = a;
    e.d = d;
    st_q.push_back(e);
  endtask
  task automatic exp_in(input logic [7:0] c, input logic eof, input int w);
    in_t e;
    e.c = c;
    e.eof = eof;
    e.w = w;
    in_q.push_back(e);
  endtask
  task automatic wait_halt(input int max);
    cyc = 0;
    while (bus.halted !== 1'b1 && cyc < max) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("halt_reached", {31'd0, bus.halted}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("sb_store_empty", st_q.size(), 0);
    check("sb_out_empty", out_q.size(), 0);
    check("sb_in_empty", in_q.size(), 0);
  endtask
  task automatic run(input int max);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    wait_halt(max);
  endtask
  initial begin
    int mcnt;
    mcnt = 0;
    bus.dmem_ack = 0;
    bus.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst || bus.dmem_ack) begin
        bus.dmem_ack = 0;
        mcnt = 0;
      end else if (bus.dmem_req) begin
        mcnt++;
        if (mcnt >= mem_dly) begin
          bus.dmem_ack = 1;
          bus.dmem_rdata = mem[bus.dmem_addr];
          if (bus.dmem_we) mem[bus.dmem_addr] = bus.dmem_wdata;
        end
      end
    end
  end
  initial begin
    int icnt;
    in_t it;
    icnt = 0;
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.in_eof = 0;
    forever begin
      @(negedge clk);
      if (rst || bus.in_valid) begin
        bus.in_valid = 0;
        icnt = 0;
      end else if (bus.in_ready && in_q.size() > 0) begin
        icnt++;
        if (icnt > in_q[0].w) begin
          it = in_q.pop_front();
          cur_wait = it.w;
          bus.in_data = it.c;
          bus.in_eof = it.eof;
          bus.in_valid = 1;
        end
      end
    end
  end
  initial begin
    st_t e;
    logic [7:0] oc;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        req_cyc = 0;
        rdy_cyc = 0;
      end else begin
        if (bus.dmem_req) req_cyc++;
        if (bus.in_ready) rdy_cyc++;
        if (bus.dmem_req && bus.dmem_ack) begin
          check("req_cycles", req_cyc, mem_dly);
          req_cyc = 0;
          if (bus.dmem_we) begin
            if (st_q.size() == 0) check("store_unexpected", 1, 0);
            else begin
              e = st_q.pop_front();
              check("store_addr", {20'd0, bus.dmem_addr}, {20'd0, e.a});
              check("store_data", {8'd0, bus.dmem_wdata}, {8'd0, e.d});
            end
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          beats++;
          if (out_q.size() == 0) check("putc_unexpected", 1, 0);
          else begin
            oc = out_q.pop_front();
            check("putc_data", {24'd0, bus.out_data}, {24'd0, oc});
          end
        end
        if (bus.in_ready && bus.in_valid) begin
          check("getc_ready_cycles", rdy_cyc, cur_wait + 1);
          rdy_cyc = 0;
        end
      end
    end
  end
  initial begin
    rst = 1;
    bus.out_ready = 0;
    foreach (mem[i]) mem[i] = '0;
    clear_rom();
    @(posedge clk);
    #1;
    check("rst_halted", {31'd0, bus.halted}, 0);
    check("rst_pc", {24'd0, bus.imem_addr}, 0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 0);
    check("rst_out_data", {24'd0, bus.out_data}, 0);
    check("rst_dmem_req", {31'd0, bus.dmem_req}, 0);
    check("rst_dmem_bus", {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata[18:0]}, 0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 0);
    // mov/putc/exit
    rom[0] = ins(OP_MOV, 1, REG_A, 0, 12'd72);
    rom[1] = ins(OP_PUTC, 0, REG_A, 0, 12'd0);
    rom[2] = ins(OP_EXIT, 0, 0, 0, 12'd0);
    out_q.push_back(8'h48);
    bus.out_ready = 1;
    beats = 0;
    run(100);
    check("halt_cycle", cyc, 7);
    check("pc_frozen", {24'd0, bus.imem_addr}, 2);
    check("beats_t1", beats, 1);
    // arithmetic wrap and every compare (unsigned)
    clear_rom();
    rom[0]  = ins(OP_MOV, 1, REG_A, 0, 12'd5);
    rom[1]  = ins(OP_MOV, 1, REG_B, 0, 12'd7);
    rom[2]  = ins(OP_SUB, 0, REG_A, REG_B, 12'd0);
    rom[3]  = ins(OP_STORE, 1, REG_A, 0, 12'h020);
    rom[4]  = ins(OP_LT, 1, REG_A, 0, 12'd1);
    rom[5]  = ins(OP_STORE, 1, REG_A, 0, 12'h021);
    rom[6]  = ins(OP_MOV, 1, REG_C, 0, 12'd3);
    rom[7]  = ins(OP_GE, 1, REG_C, 0, 12'd3);
    rom[8]  = ins(OP_STORE, 1, REG_C, 0, 12'h022);
    rom[9]  = ins(OP_ADD, 1, REG_D, 0, 12'hFFF);
    rom[10] = ins(OP_ADD, 1, REG_D, 0, 12'hFFF);
    rom[11] = ins(OP_GT, 0, REG_D, REG_B, 12'd0);
    rom[12] = ins(OP_STORE, 1, REG_D, 0, 12'h023);
    rom[13] = ins(OP_MOV, 1, REG_SP, 0, 12'd9);
    rom[14] = ins(OP_NE, 1, REG_SP, 0, 12'd9);
    rom[15] = ins(OP_EQ, 1, REG_BP, 0, 12'd0);
    rom[16] = ins(OP_STORE, 1, REG_SP, 0, 12'h024);
    rom[17] = ins(OP_STORE, 1, REG_BP, 0, 12'h025);
    rom[18] = ins(OP_LE, 1, REG_A, 0, 12'd0);
    rom[19] = ins(OP_STORE, 1, REG_A, 0, 12'h026);
    rom[20] = ins(OP_EXIT, 0, 0, 0, 12'd0);
    exp_st(12'h020, 24'hFFFFFE);
    exp_st(12'h021, 24'd0);
    exp_st(12'h022, 24'd1);
    exp_st(12'h023, 24'd1);
    exp_st(12'h024, 24'd0);
    exp_st(12'h025, 24'd1);
    exp_st(12'h026, 24'd1);
    run(300);
    // store/load through a slow memory
    clear_rom();
    mem_dly = 3;
    rom[0] = ins(OP_MOV, 1, REG_B, 0, 12'h010);
    rom[1] = ins(OP_MOV, 1, REG_A, 0, 12'hABC);
    rom[2] = ins(OP_STORE, 0, REG_A, REG_B, 12'd0);
    rom[3] = ins(OP_LOAD, 0, REG_C, REG_B, 12'd0);
    rom[4] = ins(OP_STORE, 1, REG_C, 0, 12'h030);
    rom[5] = ins(OP_EXIT, 0, 0, 0, 12'd0);
    exp_st(12'h010, 24'hABC);
    exp_st(12'h030, 24'hABC);
    run(200);
    mem_dly = 1;
    // loop, register jump with pc wrap, immediate jump
    clear_rom();
    rom[0]     = ins(OP_JNE, 1, REG_C, 3'd6, 12'h020);
    rom[1]     = ins(OP_MOV, 1, REG_A, 0, 12'd0);
    rom[2]     = ins(OP_ADD, 1, REG_A, 0, 12'd1);
    rom[3]     = ins(OP_MOV, 1, REG_B, 0, 12'd3);
    rom[4]     = ins(OP_JNE, 0, REG_A, REG_B, 12'd2);
    rom[5]     = ins(OP_STORE, 1, REG_A, 0, 12'h040);
    rom[6]     = ins(OP_MOV, 1, REG_D, 0, 12'h0FF);
    rom[7]     = ins(OP_JMP, 0, 0, REG_D, 12'd0);
    rom[8'hFF] = ins(OP_MOV, 1, REG_C, 0, 12'h077);
    rom[8'h20] = ins(OP_STORE, 1, REG_C, 0, 12'h041);
    rom[8'h21] = ins(OP_JMP, 1, 0, 0, 12'h030);
    rom[8'h30] = ins(OP_EXIT, 0, 0, 0, 12'd0);
    exp_st(12'h040, 24'd3);
    exp_st(12'h041, 24'h77);
    run(400);
    check("pc_after_jmp", {24'd0, bus.imem_addr}, 32'h30);
    // getc with a late character, then end of input
    clear_rom();
    rom[0] = ins(OP_MOV, 1, REG_B, 0, 12'h099);
    rom[1] = ins(OP_GETC, 0, REG_A, 0, 12'd0);
    rom[2] = ins(OP_STORE, 1, REG_A, 0, 12'h050);
    rom[3] = ins(OP_GETC, 0, REG_B, 0, 12'd0);
    rom[4] = ins(OP_STORE, 1, REG_B, 0, 12'h051);
    rom[5] = ins(OP_PUTC, 0, REG_A, 0, 12'd0);
    rom[6] = ins(OP_EXIT, 0, 0, 0, 12'd0);
    exp_in(8'h5A, 1'b0, 5);
    exp_in(8'h33, 1'b1, 0);
    exp_st(12'h050, 24'h5A);
    exp_st(12'h051, 24'd0);
    out_q.push_back(8'h5A);
    run(300);
    // reset while putc is stalled
    clear_rom();
    rom[0] = ins(OP_MOV, 1, REG_A, 0, 12'h041);
    rom[1] = ins(OP_PUTC, 0, REG_A, 0, 12'd0);
    rom[2] = ins(OP_EXIT, 0, 0, 0, 12'd0);
    bus.out_ready = 0;
    beats = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("putc_valid_seen", {31'd0, bus.out_valid}, 1);
    repeat (3) @(posedge clk);
    #1;
    check("putc_valid_held", {31'd0, bus.out_valid}, 1);
    check("putc_data_held", {24'd0, bus.out_data}, 32'h41);
    check("putc_pc_held", {24'd0, bus.imem_addr}, 1);
    @(negedge clk);
    rst = 1;
    bus.out_ready = 1;
    @(posedge clk);
    #1;
    check("rst_mid_valid", {31'd0, bus.out_valid}, 0);
    check("rst_mid_pc", {24'd0, bus.imem_addr}, 0);
    clear_rom();
    rom[0] = ins(OP_STORE, 1, REG_A, 0, 12'h060);
    rom[1] = ins(OP_STORE, 1, REG_B, 0, 12'h061);
    rom[2] = ins(OP_EXIT, 0, 0, 0, 12'd0);
    exp_st(12'h060, 24'd0);
    exp_st(12'h061, 24'd0);
    @(negedge clk);
    rst = 0;
    wait_halt(100);
    check("beats_after_rst", beats, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
